// File: rtl/alu_result_reader_if.sv
// Shared ALU result bus plus the sequencer-side request/response signals of the reader.
// Latency: none (wires only); timing is set by alu_result_reader.
// Backpressure: none; start is only accepted while busy is low, otherwise dropped.
interface alu_result_reader_if #(
    parameter int NUM_UNITS = 4,
    parameter int SEL_W     = 2
) ();
    logic                 start;
    logic [SEL_W-1:0]     unit_sel;
    logic                 clear;
    logic [7:0]           result_bus;
    logic [2:0]           flags_bus;
    logic [NUM_UNITS-1:0] oe;
    logic [7:0]           acc;
    logic [2:0]           status;
    logic                 busy;
    logic                 done;
    logic                 sel_err;

    // Control sequencer and functional units drive requests and the bus.
    modport master (
        output start, unit_sel, clear, result_bus, flags_bus,
        input  oe, acc, status, busy, done, sel_err
    );

    // The reader consumes requests and the bus, drives enables and results.
    modport slave (
        input  start, unit_sel, clear, result_bus, flags_bus,
        output oe, acc, status, busy, done, sel_err
    );
endinterface

// File: rtl/alu_result_reader.sv
// Selects one functional unit onto the shared ALU bus, captures result/flags into acc/status.
// Latency: done pulses SETTLE_CYCLES+2 cycles after start is sampled (1 cycle for a bad select).
// Backpressure: start/clear are ignored while busy; option ALU_RESULT_READER_ZFLAG_EN derives zero flag.
module alu_result_reader #(
    parameter int NUM_UNITS     = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input logic              clock,
    input logic              nreset,
    alu_result_reader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [NUM_UNITS-1:0] oe_q, oe_n;
    logic [7:0]           acc_q, acc_n;
    logic [2:0]           status_q, status_n;
    logic                 done_q, done_n;
    logic                 sel_err_q, sel_err_n;
    logic                 sel_ok;
    logic [2:0]           cap_status;

    assign sel_ok = (int'(bus.unit_sel) < NUM_UNITS);

`ifdef ALU_RESULT_READER_ZFLAG_EN
    // Zero flag is recomputed from the captured result; the unit's own zero flag is discarded.
    logic unused_flag_zero;
    assign unused_flag_zero = bus.flags_bus[0];
    assign cap_status = {bus.flags_bus[2:1], (bus.result_bus == 8'h00)};
`else
    // Flags are taken exactly as the functional unit presents them.
    assign cap_status = bus.flags_bus;
`endif

    // State and output registers; reset drops oe immediately so no unit keeps driving the bus.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            oe_q      <= '0;
            acc_q     <= 8'h00;
            status_q  <= 3'b000;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            oe_q      <= oe_n;
            acc_q     <= acc_n;
            status_q  <= status_n;
            done_q    <= done_n;
            sel_err_q <= sel_err_n;
        end
    end

    // Next-state logic. The one-hot oe register itself holds the latched selection during DRIVE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        oe_n      = oe_q;
        acc_n     = acc_q;
        status_n  = status_q;
        done_n    = 1'b0;
        sel_err_n = 1'b0;
        case (state)
            IDLE: begin
                // Clear and start may coincide; the later capture overwrites the cleared value.
                if (bus.clear) begin
                    acc_n    = 8'h00;
                    status_n = 3'b000;
                end
                if (bus.start) begin
                    if (sel_ok) begin
                        state_n = DRIVE;
                        cnt_n   = 4'(SETTLE_CYCLES);
                        for (int i = 0; i < NUM_UNITS; i++) begin
                            oe_n[i] = (int'(bus.unit_sel) == i);
                        end
                    end else begin
                        // Nonexistent unit: report completion with an error, never touch the bus.
                        state_n   = DONE;
                        done_n    = 1'b1;
                        sel_err_n = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    // Final edge of the oe window: sample the bus and release it together.
                    acc_n    = bus.result_bus;
                    status_n = cap_status;
                    oe_n     = '0;
                    state_n  = DONE;
                    done_n   = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                oe_n    = '0;
            end
        endcase
    end

    assign bus.oe      = oe_q;
    assign bus.acc     = acc_q;
    assign bus.status  = status_q;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.sel_err = sel_err_q;

endmodule
